// File: rtl/bus_arbiter2x16_pkg.sv
// Shared definitions for the two-requester round-robin bus arbiter.
// Contents:
//   - default data width and burst limit
//   - FSM state encoding
//   - beat-counter width helper
package bus_arbiter2x16_pkg;

   localparam int unsigned DEF_WIDTH     = 16;
   localparam int unsigned DEF_MAX_BURST = 4;

   // Arbiter state encoding; gnt0/gnt1 are decoded straight from these codes.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   // Counter width able to hold 0..max_burst-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_burst);
      int unsigned w;
      w = 1;
      while ((max_burst > 1) && ((32'd1 << w) < max_burst))
         w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/bus_arbiter2x16_mux.sv
// Enabled 2:1 operand/bus mux (MUX2x16 datapath).
// Ports:
//   a, b  - source operands (select 0 / select 1)
//   sel   - 0 picks a, 1 picks b
//   en    - mux enable; output is forced to zero when low
//   y_c   - combinational mux output
module bus_arbiter2x16_mux
   import bus_arbiter2x16_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   input  logic             en,
   output logic [WIDTH-1:0] y_c
);

   // Zero when disabled so an idle bus never leaks stale operands.
   always_comb begin
      y_c = '0;
      if (en) begin
         y_c = sel ? b : a;
      end
   end

endmodule

// File: rtl/bus_arbiter2x16.sv
// Two-requester round-robin arbiter sequencing bursts through a shared
// 2:1 mux into a one-stage valid/ready output register.
// Ports:
//   clk, reset       - clock and synchronous active-high reset
//   req0/req1        - bus requests, held for the whole burst
//   data0/data1      - beat data of each requester
//   last0/last1      - current beat is the final beat of its burst
//   gnt0/gnt1        - mux ownership, decoded from the state register
//   out_data         - registered muxed beat
//   out_valid        - out_data holds an unconsumed beat
//   out_ready        - consumer accepts out_data this cycle
module bus_arbiter2x16
   import bus_arbiter2x16_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   input  logic             last0,
   input  logic             last1,
   output logic             gnt0,
   output logic             gnt1,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned     CNT_W   = cnt_width(MAX_BURST);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               rr_ptr;
   logic               rr_nxt;
   logic               valid_nxt;
   logic [WIDTH-1:0]   data_nxt;

   logic               mux_en_c;
   logic               mux_sel_c;
   logic [WIDTH-1:0]   mux_y_c;
   logic               take_c;
   logic               req_cur_c;
   logic               last_cur_c;
   logic               other_c;
   logic               accept_c;
   logic               burst_end_c;

   // Grants come straight from the state register, so they are glitch-free
   // and mutually exclusive by construction.
   assign gnt0 = (state == GRANT0);
   assign gnt1 = (state == GRANT1);

   assign mux_en_c  = gnt0 | gnt1;
   assign mux_sel_c = gnt1;

   bus_arbiter2x16_mux #(
      .WIDTH (WIDTH)
   ) u_mux (
      .a   (data0),
      .b   (data1),
      .sel (mux_sel_c),
      .en  (mux_en_c),
      .y_c (mux_y_c)
   );

   // Signals of the currently granted requester and of the waiting one.
   assign req_cur_c  = gnt1 ? req1  : req0;
   assign last_cur_c = gnt1 ? last1 : last0;
   assign other_c    = gnt1 ? req0  : req1;

   // Output register can take a beat when empty or being drained this cycle.
   assign take_c   = !out_valid || out_ready;
   assign accept_c = mux_en_c && req_cur_c && take_c;

   // Grant ends on a last beat, or on the burst limit while the other side waits.
   assign burst_end_c = accept_c &&
                        (last_cur_c || ((cnt == CNT_MAX) && other_c));

   // Next-state, counter, round-robin pointer and output register update.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rr_nxt    = rr_ptr;
      valid_nxt = out_valid;
      data_nxt  = out_data;

      if (out_valid && out_ready) begin
         valid_nxt = 1'b0;
      end
      // An accepted beat overrides the drain so back-to-back beats stream.
      if (accept_c) begin
         valid_nxt = 1'b1;
         data_nxt  = mux_y_c;
      end

      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (req0 && (!req1 || !rr_ptr)) begin
               state_nxt = GRANT0;
            end else if (req1) begin
               state_nxt = GRANT1;
            end
         end

         GRANT0, GRANT1: begin
            if (!req_cur_c || burst_end_c) begin
               // Withdrawal or burst end: hand priority to the other side.
               state_nxt = IDLE;
               rr_nxt    = (state == GRANT0);
               cnt_nxt   = '0;
            end else if (accept_c && (cnt != CNT_MAX)) begin
               // Saturating count lets a lone requester hold the bus forever.
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         rr_ptr    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rr_ptr    <= rr_nxt;
         out_valid <= valid_nxt;
         out_data  <= data_nxt;
      end
   end

endmodule

// File: tb/tb_bus_arbiter2x16.sv
// Scoreboard bench for bus_arbiter2x16: directed scenarios push expected
// beats; a negedge monitor pops and compares every consumed output beat.
module tb_bus_arbiter2x16;

   logic        clk;
   logic        reset;
   logic        req0;
   logic        req1;
   logic [15:0] data0;
   logic [15:0] data1;
   logic        last0;
   logic        last1;
   logic        gnt0;
   logic        gnt1;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_beat;

   bus_arbiter2x16 #(
      .WIDTH     (16),
      .MAX_BURST (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req0      (req0),
      .req1      (req1),
      .data0     (data0),
      .data1     (data1),
      .last0     (last0),
      .last1     (last1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   // Monitor: every beat handed to the consumer must match the scoreboard.
   always @(negedge clk) begin
      if (gnt0 && gnt1) begin
         checks++;
         errors++;
         $display("FAIL gnt_exclusive: got gnt0=%b gnt1=%b required not both 1", gnt0, gnt1);
      end
      if (out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got beat %h required none", out_data);
         end else begin
            exp_beat = exp_q.pop_front();
            if (out_data !== exp_beat) begin
               errors++;
               $display("FAIL sb_beat: got %h required %h", out_data, exp_beat);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic chk_gnt(input string name, input logic [1:0] exp);
      check(name, 32'({gnt0, gnt1}), 32'(exp));
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req0      = 1'b0;
      req1      = 1'b0;
      last0     = 1'b0;
      last1     = 1'b0;
      data0     = '0;
      data1     = '0;
      out_ready = 1'b1;
      tick();
      tick();
      check("rst_outputs", 32'({gnt0, gnt1, out_valid, out_data}), 32'd0);
      reset = 1'b0;
   endtask

   initial begin
      // Reset then idle
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_outputs", 32'({gnt0, gnt1, out_valid, out_data}), 32'd0);
      end

      // Single 3-beat burst from requester 0
      do_reset();
      exp_q.push_back(16'hA5A0);
      exp_q.push_back(16'hA5A1);
      exp_q.push_back(16'hA5A2);
      req0 = 1'b1; data0 = 16'hA5A0;
      tick(); chk_gnt("burst_gnt_rise", 2'b10);
      tick(); chk_gnt("burst_gnt_b1", 2'b10);
      data0 = 16'hA5A1;
      tick(); chk_gnt("burst_gnt_b2", 2'b10);
      data0 = 16'hA5A2; last0 = 1'b1;
      tick(); chk_gnt("burst_idle", 2'b00);
      req0 = 1'b0; last0 = 1'b0;
      tick(); check("burst_drained", 32'(out_valid), 32'd0);

      // Tie with 1-beat bursts: strict alternation with one idle bubble
      do_reset();
      req0 = 1'b1; req1 = 1'b1; last0 = 1'b1; last1 = 1'b1;
      data0 = 16'h1111; data1 = 16'h2222;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(16'h1111);
         exp_q.push_back(16'h2222);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         chk_gnt("tie_gnt", (i % 4 == 0) ? 2'b10 : ((i % 4 == 2) ? 2'b01 : 2'b00));
      end
      req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
      tick();

      // Preemption after MAX_BURST beats, then requester 0 resumes
      do_reset();
      for (int k = 1; k <= 4; k++) exp_q.push_back(16'(k));
      exp_q.push_back(16'hB001);
      exp_q.push_back(16'hB002);
      for (int k = 5; k <= 10; k++) exp_q.push_back(16'(k));
      req0 = 1'b1; data0 = 16'h0001;
      tick(); chk_gnt("pre_gnt0", 2'b10);
      tick();
      data0 = 16'h0002; req1 = 1'b1; data1 = 16'hB001;
      tick();
      data0 = 16'h0003;
      tick(); chk_gnt("pre_gnt0_beat4", 2'b10);
      data0 = 16'h0004;
      tick(); chk_gnt("pre_bubble", 2'b00);
      data0 = 16'h0005;
      tick(); chk_gnt("pre_gnt1", 2'b01);
      tick(); chk_gnt("pre_gnt1_hold", 2'b01);
      data1 = 16'hB002; last1 = 1'b1;
      tick(); chk_gnt("pre_bubble2", 2'b00);
      req1 = 1'b0; last1 = 1'b0;
      tick(); chk_gnt("pre_resume", 2'b10);
      tick();
      for (int k = 6; k <= 10; k++) begin
         data0 = 16'(k);
         if (k == 10) last0 = 1'b1;
         tick();
      end
      chk_gnt("pre_done", 2'b00);
      req0 = 1'b0; last0 = 1'b0;
      tick();

      // Backpressure: BEEF held for three stalled cycles
      do_reset();
      exp_q.push_back(16'h1110);
      exp_q.push_back(16'hBEEF);
      exp_q.push_back(16'h1112);
      req1 = 1'b1; data1 = 16'h1110;
      tick(); chk_gnt("bp_gnt1", 2'b01);
      tick();
      data1 = 16'hBEEF;
      tick();
      out_ready = 1'b0; data1 = 16'h1112; last1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_data", 32'(out_data), 32'h0000BEEF);
         chk_gnt("bp_gnt_hold", 2'b01);
         tick();
      end
      out_ready = 1'b1;
      check("bp_data_release", 32'(out_data), 32'h0000BEEF);
      tick(); chk_gnt("bp_end", 2'b00);
      check("bp_last_beat", 32'(out_data), 32'h00001112);
      req1 = 1'b0; last1 = 1'b0;
      tick();

      // Reset in the middle of a requester-1 burst
      do_reset();
      exp_q.push_back(16'h0C00);
      exp_q.push_back(16'hD001);
      req0 = 1'b1; last0 = 1'b1; data0 = 16'h0C00;
      tick(); chk_gnt("mr_gnt0", 2'b10);
      tick();
      req0 = 1'b0; last0 = 1'b0; req1 = 1'b1; data1 = 16'hD001;
      tick(); chk_gnt("mr_gnt1", 2'b01);
      tick();
      data1 = 16'hD002; reset = 1'b1;
      tick();
      check("mr_cleared", 32'({gnt0, gnt1, out_valid, out_data}), 32'd0);
      reset = 1'b0;
      req0 = 1'b1; req1 = 1'b1; last0 = 1'b1; last1 = 1'b1;
      data0 = 16'h0E00; data1 = 16'h0E01;
      exp_q.push_back(16'h0E00);
      exp_q.push_back(16'h0E01);
      tick(); chk_gnt("mr_tie_first", 2'b10);
      tick(); chk_gnt("mr_tie_bubble", 2'b00);
      tick(); chk_gnt("mr_tie_second", 2'b01);
      tick(); chk_gnt("mr_tie_done", 2'b00);
      req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;

      repeat (3) tick();
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
